wb_ram_responder: RTL

//   Wishbone B4 pipelined-mode responder (target end of the bus the sim driver initiates on).

---
 rtl/wb_ram_if.sv | 24 ++
 rtl/wb_ram_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/wb_ram_if.sv
// Wishbone B4 pipelined bus bundle between an initiator and a RAM-style target.
interface wb_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  we;
  logic                  cycle;
  logic                  strobe;
  logic                  stall;
  logic                  ack;

  modport master (
    output addr, data_wr, we, cycle, strobe,
    input  data_rd, stall, ack
  );

  modport slave (
    input  addr, data_wr, we, cycle, strobe,
    output data_rd, stall, ack
  );
endinterface

// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined target backed by a 2**ADDR_WIDTH word RAM, with a fixed number of
// wait states between accept and ack and one outstanding request at a time.
module wb_ram_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic     wb_clock_i,
  input  logic     wb_reset_i,
  wb_ram_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state_p0;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt_p0;
  logic [CNT_W-1:0]        cnt_nx;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic                    we_p0;
  logic [DATA_WIDTH-1:0]   rdata_p0;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    enter_ack;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    acc_we;

  assign accept    = (state_p0 == S_IDLE) && bus.cycle && bus.strobe;
  assign enter_ack = (state_nx == S_ACK);

  // With zero wait states the RAM is touched on the accept edge itself, before the
  // request has been latched, so the bus values are used directly from IDLE.
  assign acc_addr = (state_p0 == S_IDLE) ? bus.addr    : addr_p0;
  assign acc_data = (state_p0 == S_IDLE) ? bus.data_wr : wdata_p0;
  assign acc_we   = (state_p0 == S_IDLE) ? bus.we      : we_p0;

  always_comb begin
    state_nx = state_p0;
    cnt_nx   = cnt_p0;
    case (state_p0)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nx = S_ACK;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.cycle) begin
          state_nx = S_IDLE;
        end else if (cnt_p0 == '0) begin
          state_nx = S_ACK;
        end else begin
          cnt_nx = cnt_p0 - 1'b1;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      we_p0    <= 1'b0;
      rdata_p0 <= '0;
    end else begin
      state_p0 <= state_nx;
      cnt_p0   <= cnt_nx;
      if (accept) begin
        addr_p0  <= bus.addr;
        wdata_p0 <= bus.data_wr;
        we_p0    <= bus.we;
      end
      if (enter_ack && !acc_we) begin
        rdata_p0 <= mem[acc_addr];
      end
    end
  end

  // Contents survive reset; a reset landing on the commit edge discards the write.
  always_ff @(posedge wb_clock_i) begin
    if (!wb_reset_i && enter_ack && acc_we) begin
      mem[acc_addr] <= acc_data;
    end
  end

  assign bus.stall   = (state_p0 != S_IDLE);
  assign bus.ack     = (state_p0 == S_ACK) && bus.cycle;
  assign bus.data_rd = rdata_p0;
endmodule
